bist_compare_sequencer: RTL and testbench
=========================================

Name: bist_compare_sequencer

Overview:
On-chip self-test sequencer for a golden/post-route design pair that share one stimulus bus.
- Holds the pair in reset, then applies a pseudo-random vector stream from an internal LFSR.
- Waits a fixed settle time per vector, then compares the two response buses bit-exactly.
- Counts mismatches and vectors, and reports pass/fail.
- Sits between the harness control/status interface and the two DUT instances.

Parameters:
STIM_W, 8, stimulus width driven to both DUTs (1..32)
RESP_W, 32, response width compared
NUM_VECTORS, 1000, random vectors per run (>=1)
SETTLE_CYCLES, 2, cycles from stimulus update to compare (>=1)
INIT_CYCLES, 2, cycles dut_rst is held asserted before the reset-phase compare (>=1)
CNT_W, 16, width of vector and mismatch counters
LFSR_SEED, 32'h1, nonzero LFSR reset value

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  single-cycle pulse; accepted only in IDLE or DONE
dut_rst  out  1  active-high reset driven to both DUTs
stim  out  STIM_W  stimulus driven to both DUTs
resp_golden  in  RESP_W  golden response
resp_netlist  in  RESP_W  netlist response
busy  out  1  high in INIT, APPLY, SETTLE, CMP
done  out  1  high in DONE until the next start
pass  out  1  valid when done; 1 iff mismatch_cnt==0
cmp_valid  out  1  one-cycle pulse on every compare
cmp_match  out  1  result of that compare, valid with cmp_valid
vec_cnt  out  CNT_W  vectors compared since start (excludes reset-phase compare)
mismatch_cnt  out  CNT_W  mismatching compares since start, saturating

Behaviour:
- Reset (rst=0), applied asynchronously:
  - state IDLE; dut_rst=1; stim=0; LFSR=LFSR_SEED.
  - busy, done, pass, cmp_valid, cmp_match = 0.
  - vec_cnt, mismatch_cnt = 0.
- IDLE: dut_rst=1, stim=0.
  - On start: clear both counters, reload LFSR_SEED, enter INIT.
- INIT: dut_rst=1, stim=0 for INIT_CYCLES cycles.
  - Last INIT cycle: compare responses (cmp_valid pulse). A mismatch increments mismatch_cnt; vec_cnt is unchanged.
  - Next cycle: dut_rst=0, enter APPLY.
- APPLY (1 cycle):
  - stim <= LFSR[STIM_W-1:0] (registered, visible next cycle).
  - Step the LFSR: 32-bit Galois, polynomial from the package.
  - Enter SETTLE.
- SETTLE: count SETTLE_CYCLES-1 cycles, then enter CMP.
  - stim is stable for exactly SETTLE_CYCLES cycles before the compare.
- CMP (1 cycle): cmp_valid=1, cmp_match = (resp_golden === resp_netlist).
  - Any X/Z or bit difference counts as a mismatch.
  - vec_cnt+1; mismatch_cnt+1 on mismatch, saturating at all-ones.
  - If vec_cnt reaches NUM_VECTORS, enter DONE; otherwise enter APPLY.
- DONE: done=1, pass=(mismatch_cnt==0); stim holds its last value; dut_rst=0.
  - On start: restart as from IDLE.
- start while busy: ignored, no effect.
- vec_cnt is CNT_W wide. NUM_VECTORS >= 2**CNT_W is illegal; flag it with an elaboration-time assertion.
- Latency per vector: 1 + SETTLE_CYCLES cycles. Total run = INIT_CYCLES + 1 + NUM_VECTORS*(1+SETTLE_CYCLES) cycles from start to done.
- rst asserted mid-run: immediate return to the reset state. No partial status is retained.

Optional Feature:
FIRST_FAIL_CAPTURE_EN
- Defined: adds outputs ff_valid(1), ff_index(CNT_W), ff_golden(RESP_W), ff_netlist(RESP_W).
  - Latched on the first mismatching compare since start; held until the next start or reset.
  - ff_index = vec_cnt value before the increment; the reset-phase compare reports index all-ones.
- Undefined: these ports and their registers do not exist. Other behaviour is identical.

Decomposition:
- Package bist_seq_pkg:
  - state enum (IDLE, INIT, APPLY, SETTLE, CMP, DONE)
  - LFSR_POLY = 32'h8020_0003
  - default seed constant
- Sub-module bist_lfsr: 32-bit Galois LFSR with load/step enables; instantiated once.

Test Plan:
- Reset, start, equal responses (tie resp_netlist=resp_golden), NUM_VECTORS=4, SETTLE_CYCLES=2 -> done 2+1+12=15 cycles after start; pass=1; vec_cnt=4; mismatch_cnt=0; 5 cmp_valid pulses.
- Force resp_netlist = resp_golden^32'h1 only during vector 2 -> mismatch_cnt=1, pass=0; with FIRST_FAIL_CAPTURE_EN: ff_index=1, ff_netlist^ff_golden=32'h1.
- Mismatch only during INIT -> mismatch_cnt=1, vec_cnt=NUM_VECTORS; ff_index=16'hFFFF with the macro defined.
- Pulse start during SETTLE -> no restart; counters continue; done at nominal time.
- Drop rst for 1 cycle during vector 3 -> busy=0, dut_rst=1, counters 0, stim=0 immediately; a new start reproduces the seed-identical stim sequence.
- CNT_W=4, NUM_VECTORS=15, responses always differing -> mismatch_cnt saturates at 4'hF (16 compares incl. INIT); pass=0.

Source files
------------

// File: rtl/bist_seq_pkg.sv
// Shared types and constants for the BIST compare sequencer.
// State encoding, LFSR polynomial, default seed and the LFSR step function.
package bist_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        APPLY,
        SETTLE,
        CMP,
        DONE
    } state_t;

    localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED_DEF = 32'h0000_0001;

    // Right-shifting Galois form: the bit shifted out folds the taps back in.
    function automatic logic [31:0] lfsr_next(input logic [31:0] q);
        return (q >> 1) ^ (q[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// 32-bit Galois LFSR with synchronous load and step enables.
// Only the low OUT_W bits leave the block.
module bist_lfsr
    import bist_seq_pkg::*;
#(
    parameter logic [31:0] SEED  = LFSR_SEED_DEF,
    parameter int          OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [OUT_W-1:0] q
);

    logic [31:0] r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= SEED;
        end else if (load) begin
            r <= SEED;
        end else if (step) begin
            r <= lfsr_next(r);
        end
    end

    assign q = r[OUT_W-1:0];

endmodule

// File: rtl/bist_compare_sequencer.sv
// Self-test sequencer driving a golden/netlist pair and comparing responses.
// Optional FIRST_FAIL_CAPTURE_EN adds first-mismatch capture outputs.
module bist_compare_sequencer
    import bist_seq_pkg::*;
#(
    parameter int          STIM_W        = 8,
    parameter int          RESP_W        = 32,
    parameter int          NUM_VECTORS   = 1000,
    parameter int          SETTLE_CYCLES = 2,
    parameter int          INIT_CYCLES   = 2,
    parameter int          CNT_W         = 16,
    parameter logic [31:0] LFSR_SEED     = LFSR_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              dut_rst,
    output logic [STIM_W-1:0] stim,
    input  logic [RESP_W-1:0] resp_golden,
    input  logic [RESP_W-1:0] resp_netlist,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              cmp_valid,
    output logic              cmp_match,
    output logic [CNT_W-1:0]  vec_cnt,
    output logic [CNT_W-1:0]  mismatch_cnt
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    output logic              ff_valid,
    output logic [CNT_W-1:0]  ff_index,
    output logic [RESP_W-1:0] ff_golden,
    output logic [RESP_W-1:0] ff_netlist
`endif
);

    localparam int TMR_MAX = (INIT_CYCLES > SETTLE_CYCLES) ?
                             INIT_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] INIT_LAST = TMR_W'(INIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] SET_LAST  =
        TMR_W'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] VEC_LAST  = CNT_W'(NUM_VECTORS - 1);

    if (64'(NUM_VECTORS) >= (64'd1 << CNT_W)) begin : g_bad_num_vectors
        $error("NUM_VECTORS must be below 2**CNT_W");
    end

    state_t            state;
    state_t            state_nx;
    logic [TMR_W-1:0]  tmr;
    logic [STIM_W-1:0] lfsr_q;
    logic              go;
    logic              step;
    logic              miss;

    assign go   = start && (state == IDLE || state == DONE);
    assign miss = cmp_valid && !cmp_match;

    bist_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (STIM_W)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (go),
        .step (step),
        .q    (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        dut_rst   = 1'b0;
        cmp_valid = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                dut_rst = 1'b1;
                if (start) state_nx = INIT;
            end
            INIT: begin
                busy    = 1'b1;
                dut_rst = 1'b1;
                if (tmr == INIT_LAST) begin
                    cmp_valid = 1'b1;
                    state_nx  = APPLY;
                end
            end
            APPLY: begin
                busy     = 1'b1;
                step     = 1'b1;
                state_nx = (SETTLE_CYCLES > 1) ? SETTLE : CMP;
            end
            SETTLE: begin
                busy = 1'b1;
                if (tmr == SET_LAST) state_nx = CMP;
            end
            CMP: begin
                busy      = 1'b1;
                cmp_valid = 1'b1;
                state_nx  = (vec_cnt == VEC_LAST) ? DONE : APPLY;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nx = INIT;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Four-state compare: X or Z on either bus is a mismatch.
    assign cmp_match = cmp_valid && (resp_golden === resp_netlist);
    assign pass      = done && (mismatch_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr          <= '0;
            stim         <= '0;
            vec_cnt      <= '0;
            mismatch_cnt <= '0;
        end else if (go) begin
            tmr          <= '0;
            stim         <= '0;
            vec_cnt      <= '0;
            mismatch_cnt <= '0;
        end else begin
            // One timer serves both INIT and SETTLE; it clears on exit.
            if (state == INIT || state == SETTLE) begin
                tmr <= (state_nx == state) ? tmr + TMR_W'(1) : '0;
            end
            if (state == APPLY) begin
                stim <= lfsr_q;
            end
            if (state == CMP) begin
                vec_cnt <= vec_cnt + CNT_W'(1);
            end
            if (miss && mismatch_cnt != '1) begin
                mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            end
        end
    end

`ifdef FIRST_FAIL_CAPTURE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff_valid   <= 1'b0;
            ff_index   <= '0;
            ff_golden  <= '0;
            ff_netlist <= '0;
        end else if (go) begin
            ff_valid   <= 1'b0;
            ff_index   <= '0;
            ff_golden  <= '0;
            ff_netlist <= '0;
        end else if (miss && !ff_valid) begin
            ff_valid   <= 1'b1;
            ff_index   <= (state == INIT) ? '1 : vec_cnt;
            ff_golden  <= resp_golden;
            ff_netlist <= resp_netlist;
        end
    end
`endif

endmodule

// File: tb/tb_bist_compare_sequencer.sv
// Directed bench for bist_compare_sequencer, including a small-counter
// instance that exercises mismatch saturation.
`timescale 1ns/1ps
module tb_bist_compare_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    int          mode = 0;

    logic        dut_rst, busy, done, pass, cmp_valid, cmp_match;
    logic [7:0]  stim;
    logic [31:0] resp_golden, resp_netlist;
    logic [15:0] vec_cnt, mismatch_cnt;
    logic        inj;

    logic        dut_rst2, busy2, done2, pass2, cmp_valid2, cmp_match2;
    logic [7:0]  stim2;
    logic [31:0] golden2, netlist2;
    logic [3:0]  vec_cnt2, mismatch_cnt2;

`ifdef FIRST_FAIL_CAPTURE_EN
    logic        ff_valid, ff_valid2;
    logic [15:0] ff_index;
    logic [3:0]  ff_index2;
    logic [31:0] ff_golden, ff_netlist, ff_golden2, ff_netlist2;
`endif

    int checks = 0;
    int errors = 0;
    int done_cyc;
    int npulse;
    logic [7:0] seen [4];
    logic [4:0] mseen;
    logic [7:0] exp_stim [4] = '{8'h01, 8'h03, 8'h02, 8'h01};

    always #5 clk = ~clk;

    assign inj = (mode == 1 && stim == 8'h03 && !dut_rst) ||
                 (mode == 2 && dut_rst);
    assign resp_golden  = {stim, ~stim, 8'h5A, stim};
    assign resp_netlist = resp_golden ^ {31'h0, inj};

    assign golden2  = {24'h0, stim2};
    assign netlist2 = ~golden2;

    bist_compare_sequencer #(
        .STIM_W(8), .RESP_W(32), .NUM_VECTORS(4), .SETTLE_CYCLES(2),
        .INIT_CYCLES(2), .CNT_W(16), .LFSR_SEED(32'h1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .dut_rst(dut_rst),
        .stim(stim), .resp_golden(resp_golden),
        .resp_netlist(resp_netlist), .busy(busy), .done(done),
        .pass(pass), .cmp_valid(cmp_valid), .cmp_match(cmp_match),
        .vec_cnt(vec_cnt), .mismatch_cnt(mismatch_cnt)
`ifdef FIRST_FAIL_CAPTURE_EN
        , .ff_valid(ff_valid), .ff_index(ff_index),
        .ff_golden(ff_golden), .ff_netlist(ff_netlist)
`endif
    );

    bist_compare_sequencer #(
        .STIM_W(8), .RESP_W(32), .NUM_VECTORS(15), .SETTLE_CYCLES(2),
        .INIT_CYCLES(2), .CNT_W(4), .LFSR_SEED(32'h1)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .dut_rst(dut_rst2),
        .stim(stim2), .resp_golden(golden2),
        .resp_netlist(netlist2), .busy(busy2), .done(done2),
        .pass(pass2), .cmp_valid(cmp_valid2), .cmp_match(cmp_match2),
        .vec_cnt(vec_cnt2), .mismatch_cnt(mismatch_cnt2)
`ifdef FIRST_FAIL_CAPTURE_EN
        , .ff_valid(ff_valid2), .ff_index(ff_index2),
        .ff_golden(ff_golden2), .ff_netlist(ff_netlist2)
`endif
    );

    // Starts a run and records pulses until done or a 40-cycle bound.
    task automatic run_vectors(input int pulse_at);
        done_cyc = 0;
        npulse   = 0;
        mseen    = '0;
        for (int i = 0; i < 4; i++) seen[i] = 8'h00;
        @(posedge clk); #1;
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start = (c == pulse_at);
            if (cmp_valid) begin
                if (npulse >= 1 && npulse <= 4) seen[npulse-1] = stim;
                if (npulse <= 4) mseen[npulse] = cmp_match;
                npulse++;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got %b%b%b want 000", busy, done, pass);
        end
        checks++;
        if (cmp_valid !== 1'b0 || cmp_match !== 1'b0) begin
            errors++;
            $display("FAIL reset_cmp got %b%b want 00", cmp_valid, cmp_match);
        end
        checks++;
        if (dut_rst !== 1'b1 || stim !== 8'h00) begin
            errors++;
            $display("FAIL reset_dut got %b %h want 1 00", dut_rst, stim);
        end
        checks++;
        if (vec_cnt !== 16'h0 || mismatch_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_cnt got %h %h want 0 0", vec_cnt, mismatch_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || dut_rst !== 1'b1) begin
            errors++;
            $display("FAIL idle got busy=%b dut_rst=%b want 0 1", busy, dut_rst);
        end
    endtask

    task automatic test_clean_run();
        mode = 0;
        run_vectors(0);
        checks++;
        if (done_cyc != 15) begin
            errors++;
            $display("FAIL clean_done_cycle got %0d want 15", done_cyc);
        end
        checks++;
        if (npulse != 5) begin
            errors++;
            $display("FAIL clean_pulses got %0d want 5", npulse);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen[i] !== exp_stim[i]) begin
                errors++;
                $display("FAIL clean_stim%0d got %h want %h", i, seen[i], exp_stim[i]);
            end
        end
        checks++;
        if (vec_cnt !== 16'd4 || mismatch_cnt !== 16'd0 || pass !== 1'b1) begin
            errors++;
            $display("FAIL clean_result got %0d %0d %b want 4 0 1",
                     vec_cnt, mismatch_cnt, pass);
        end
        checks++;
        if (mseen !== 5'b11111) begin
            errors++;
            $display("FAIL clean_match got %b want 11111", mseen);
        end
        checks++;
        if (dut_rst !== 1'b0 || stim !== 8'h01 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_done_outs got %b %h %b want 0 01 0",
                     dut_rst, stim, busy);
        end
    endtask

    task automatic test_mismatch_vec2();
        mode = 1;
        run_vectors(0);
        mode = 0;
        checks++;
        if (mismatch_cnt !== 16'd1 || pass !== 1'b0 || vec_cnt !== 16'd4) begin
            errors++;
            $display("FAIL vec2_result got %0d %b %0d want 1 0 4",
                     mismatch_cnt, pass, vec_cnt);
        end
        checks++;
        if (mseen !== 5'b11011) begin
            errors++;
            $display("FAIL vec2_match got %b want 11011", mseen);
        end
`ifdef FIRST_FAIL_CAPTURE_EN
        checks++;
        if (ff_valid !== 1'b1 || ff_index !== 16'd1 ||
            (ff_golden ^ ff_netlist) !== 32'h1) begin
            errors++;
            $display("FAIL vec2_ff got %b %h %h want 1 0001 00000001",
                     ff_valid, ff_index, ff_golden ^ ff_netlist);
        end
`endif
    endtask

    task automatic test_mismatch_init();
        mode = 2;
        run_vectors(0);
        mode = 0;
        checks++;
        if (mismatch_cnt !== 16'd1 || vec_cnt !== 16'd4 || pass !== 1'b0) begin
            errors++;
            $display("FAIL init_result got %0d %0d %b want 1 4 0",
                     mismatch_cnt, vec_cnt, pass);
        end
        checks++;
        if (mseen !== 5'b11110) begin
            errors++;
            $display("FAIL init_match got %b want 11110", mseen);
        end
`ifdef FIRST_FAIL_CAPTURE_EN
        checks++;
        if (ff_valid !== 1'b1 || ff_index !== 16'hFFFF) begin
            errors++;
            $display("FAIL init_ff got %b %h want 1 ffff", ff_valid, ff_index);
        end
`endif
    endtask

    task automatic test_start_while_busy();
        run_vectors(4);
        checks++;
        if (done_cyc != 15 || vec_cnt !== 16'd4 || npulse != 5) begin
            errors++;
            $display("FAIL busy_start got cyc=%0d vec=%0d pulses=%0d want 15 4 5",
                     done_cyc, vec_cnt, npulse);
        end
        checks++;
        if (seen[3] !== 8'h01 || pass !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_stim got %h %b want 01 1", seen[3], pass);
        end
    endtask

    task automatic test_rst_midrun();
        mode = 2;
        @(posedge clk); #1;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        checks++;
        if (vec_cnt !== 16'd2 || mismatch_cnt !== 16'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre got %0d %0d %b want 2 1 1",
                     vec_cnt, mismatch_cnt, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || dut_rst !== 1'b1 || stim !== 8'h00 ||
            vec_cnt !== 16'd0 || mismatch_cnt !== 16'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_rst got %b %b %h %0d %0d %b want 0 1 00 0 0 0",
                     busy, dut_rst, stim, vec_cnt, mismatch_cnt, done);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        mode = 0;
        run_vectors(0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen[i] !== exp_stim[i]) begin
                errors++;
                $display("FAIL rerun_stim%0d got %h want %h", i, seen[i], exp_stim[i]);
            end
        end
        checks++;
        if (done_cyc != 15 || pass !== 1'b1) begin
            errors++;
            $display("FAIL rerun_done got %0d %b want 15 1", done_cyc, pass);
        end
    endtask

    task automatic test_saturate();
        int dc;
        dc = 0;
        @(posedge clk); #1;
        start2 = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            if (done2) begin
                dc = c;
                break;
            end
        end
        checks++;
        if (dc != 48) begin
            errors++;
            $display("FAIL sat_done_cycle got %0d want 48", dc);
        end
        checks++;
        if (mismatch_cnt2 !== 4'hF || vec_cnt2 !== 4'hF || pass2 !== 1'b0) begin
            errors++;
            $display("FAIL sat_result got %h %h %b want f f 0",
                     mismatch_cnt2, vec_cnt2, pass2);
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_mismatch_vec2();
        test_mismatch_init();
        test_start_while_busy();
        test_rst_midrun();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
